// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit-step counter.
package serial_pkg;

    // FSM encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must reach n-1 without wrapping early.
    // Clamped to one bit so the counter always exists.
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell: s = a ^ b ^ c, co = majority(a, b, c).
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder. Operands are captured on a start strobe, summed
// LSB-first through one full-adder cell with a carry flip-flop, and the
// parallel sum, carry-out and signed overflow are presented with a
// single-cycle done pulse.
module serial_adder
    import serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  ra_q, ra_d;
    logic [N-1:0]  rb_q, rb_d;
    logic [N-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          fa_s;
    logic          fa_co;

    // Single bit-step cell fed from the shift-register LSBs and the carry flop.
    fulladder u_fa (
        .a  (ra_q[0]),
        .b  (rb_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state and datapath control; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                ra_d    = {1'b0, ra_q[N-1:1]};
                rb_d    = {1'b0, rb_q[N-1:1]};
                sum_d   = {fa_s, sum_q[N-1:1]};
                carry_d = fa_co;
                if (cnt_q == LAST_STEP) begin
                    // MSB step: carry_q is the carry into the MSB, fa_co the carry out.
                    state_d = ST_DONE;
                    cout_d  = fa_co;
                    ovf_d   = fa_co ^ carry_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // start is deliberately not sampled here; it is not queued.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
